// File: rtl/mips_timer_if.sv
// Bridge-side data-port bundle for the timer window: select, byte-addressed access, read-back.
interface mips_timer_if;
   logic        sel;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, output addr, output byteen, output wdata, input rdata);
   modport slave  (input sel, input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/mips_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// interrupt raised when COUNT is seen at zero.
module mips_timer (
   input  logic         clk,
   input  logic         reset,
   mips_timer_if.slave  bus,
   output logic         irq
);
   typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

   state_t      state, state_nx;
   logic [3:0]  ctrl, ctrl_fsm;
   logic [31:0] preset, count, count_nx;
   logic        pending, pend_set, pend_clr, en_clr;

   logic        en, auto_rl, im;
   logic        we, wr_ctrl, wr_preset;
   logic        unused_addr;

   assign en      = ctrl[0];
   assign auto_rl = (ctrl[2:1] == 2'b01);
   assign im      = ctrl[3];

   assign we        = bus.sel & (|bus.byteen);
   assign wr_ctrl   = we & (bus.addr[3:2] == 2'b00);
   assign wr_preset = we & (bus.addr[3:2] == 2'b01);
   assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   always_comb begin
      state_nx = state;
      count_nx = count;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      en_clr   = 1'b0;
      case (state)
         IDLE: if (en) state_nx = LOAD;
         LOAD: begin
            count_nx = preset;
            state_nx = CNT;
         end
         CNT: begin
            if (!en)
               state_nx = IDLE;
            else if (count != 32'd0)
               count_nx = count - 32'd1;
            else begin
               state_nx = INT;
               pend_set = 1'b1;
            end
         end
         INT: begin
            if (auto_rl) begin
               pend_clr = 1'b1;
               state_nx = LOAD;
            end else begin
               en_clr   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A CPU write to the low byte of CTRL overrides the FSM's one-shot EN clear.
   assign ctrl_fsm = en_clr ? {ctrl[3:1], 1'b0} : ctrl;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ctrl    <= 4'd0;
         preset  <= 32'd0;
         count   <= 32'd0;
         pending <= 1'b0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         ctrl    <= (wr_ctrl && bus.byteen[0]) ? bus.wdata[3:0] : ctrl_fsm;
         if (wr_preset)
            preset <= merge(preset, bus.wdata, bus.byteen);
         if (wr_ctrl || pend_clr)
            pending <= 1'b0;
         else if (pend_set)
            pending <= 1'b1;
      end
   end

   always_comb begin
      case (bus.addr[3:2])
         2'b00:   bus.rdata = {28'd0, ctrl};
         2'b01:   bus.rdata = preset;
         2'b10:   bus.rdata = count;
         default: bus.rdata = 32'd0;
      endcase
   end

   assign irq = pending & im;
endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: register-access vector table plus timed FSM sequences.
module tb_mips_timer;
   logic clk = 1'b0;
   logic reset;
   logic irq;
   int   total = 0;
   int   bad = 0;

   mips_timer_if bus ();

   mips_timer dut (.clk(clk), .reset(reset), .bus(bus.slave), .irq(irq));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        sel;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
      bus.addr = a;
      #1;
      chk(nm, bus.rdata, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      bus.sel = 1'b1; bus.addr = a; bus.wdata = d; bus.byteen = be;
      @(posedge clk);
      #1;
      bus.sel = 1'b0; bus.byteen = 4'd0;
   endtask

   initial begin
      vecs[0]  = '{"rst_ctrl",    1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b0};
      vecs[1]  = '{"rst_preset",  1'b0, 32'h4, 4'h0, 32'h0,        32'h0,        1'b0};
      vecs[2]  = '{"rst_count",   1'b0, 32'h8, 4'h0, 32'h0,        32'h0,        1'b0};
      vecs[3]  = '{"rst_unused",  1'b0, 32'hC, 4'h0, 32'h0,        32'h0,        1'b0};
      vecs[4]  = '{"wr_preset",   1'b1, 32'h4, 4'hF, 32'h11223344, 32'h0,        1'b0};
      vecs[5]  = '{"rd_preset",   1'b0, 32'h4, 4'h0, 32'h0,        32'h11223344, 1'b0};
      vecs[6]  = '{"wr_lane01",   1'b1, 32'h4, 4'h3, 32'hAABBCCDD, 32'h11223344, 1'b0};
      vecs[7]  = '{"rd_merged",   1'b0, 32'h4, 4'h0, 32'h0,        32'h1122CCDD, 1'b0};
      vecs[8]  = '{"wr_count",    1'b1, 32'h8, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[9]  = '{"count_ro",    1'b0, 32'h8, 4'h0, 32'h0,        32'h0,        1'b0};
      vecs[10] = '{"wr_unused",   1'b1, 32'hC, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[11] = '{"preset_keep", 1'b0, 32'h4, 4'h0, 32'h0,        32'h1122CCDD, 1'b0};
      vecs[12] = '{"wr_ctrl_hi",  1'b1, 32'h0, 4'hF, 32'hFFFFFFF6, 32'h0,        1'b0};
      vecs[13] = '{"ctrl_4bit",   1'b0, 32'h0, 4'h0, 32'h0,        32'h6,        1'b0};
      vecs[14] = '{"nosel_wr",    1'b0, 32'h0, 4'hF, 32'h0000000F, 32'h6,        1'b0};
      vecs[15] = '{"nosel_keep",  1'b0, 32'h0, 4'h0, 32'h0,        32'h6,        1'b0};
      vecs[16] = '{"wr_ctrl_b0",  1'b1, 32'h0, 4'h1, 32'h0,        32'h6,        1'b0};
      vecs[17] = '{"ctrl_clr",    1'b0, 32'h0, 4'h0, 32'h0,        32'h0,        1'b0};

      reset = 1'b1;
      bus.sel = 1'b0; bus.addr = 32'd0; bus.byteen = 4'd0; bus.wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.sel = vecs[i].sel; bus.addr = vecs[i].addr;
         bus.byteen = vecs[i].be; bus.wdata = vecs[i].wdata;
         #1;
         chk(vecs[i].name, bus.rdata, vecs[i].exp_rd);
         chk({vecs[i].name, "_irq"}, {31'd0, irq}, {31'd0, vecs[i].exp_irq});
         @(posedge clk);
         #1;
         bus.sel = 1'b0; bus.byteen = 4'd0;
      end

      // One-shot, PRESET=5: COUNT 5..0 then irq latched 8 cycles after the CTRL write.
      wr(32'h4, 32'd5, 4'hF);
      wr(32'h0, 32'h9, 4'hF);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         rd(32'h8, (k < 2) ? 32'd0 : ((k <= 7) ? 32'(7 - k) : 32'd0), "os_count");
         chk("os_irq", {31'd0, irq}, {31'd0, k == 8});
      end
      @(posedge clk);
      #1;
      rd(32'h0, 32'h8, "os_en_clr");
      chk("os_irq_hold", {31'd0, irq}, 32'd1);
      repeat (3) @(posedge clk);
      #1 chk("os_irq_hold2", {31'd0, irq}, 32'd1);
      wr(32'h0, 32'h0, 4'hF);
      chk("os_irq_drop", {31'd0, irq}, 32'd0);

      // Auto-reload, PRESET=2: 1-cycle pulses every 5 cycles.
      wr(32'h4, 32'd2, 4'hF);
      wr(32'h0, 32'hB, 4'hF);
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk);
         #1;
         rd(32'h0, 32'hB, "ar_ctrl");
         chk("ar_irq", {31'd0, irq}, {31'd0, (k % 5) == 0});
      end
      wr(32'h0, 32'h0, 4'hF);
      repeat (4) @(posedge clk);
      #1 chk("ar_stop_irq", {31'd0, irq}, 32'd0);

      // Disable mid-count: COUNT freezes at 50.
      wr(32'h4, 32'd100, 4'hF);
      wr(32'h0, 32'h9, 4'hF);
      repeat (51) @(posedge clk);
      #1 rd(32'h8, 32'd51, "dis_pre");
      wr(32'h0, 32'h0, 4'hF);
      rd(32'h8, 32'd50, "dis_at");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         rd(32'h8, 32'd50, "dis_frozen");
         chk("dis_irq", {31'd0, irq}, 32'd0);
      end

      // IM=0 full one-shot run: irq masked, EN self-clears.
      wr(32'h4, 32'd3, 4'hF);
      wr(32'h0, 32'h1, 4'hF);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1 chk("mask_irq", {31'd0, irq}, 32'd0);
      end
      rd(32'h0, 32'h0, "mask_en_clr");

      // Reset while counting.
      wr(32'h4, 32'd40, 4'hF);
      wr(32'h0, 32'h9, 4'hF);
      repeat (12) @(posedge clk);
      #1 rd(32'h8, 32'd30, "rst_pre");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      rd(32'h0, 32'd0, "rst_ctrl2");
      rd(32'h4, 32'd0, "rst_preset2");
      rd(32'h8, 32'd0, "rst_count2");
      chk("rst_irq2", {31'd0, irq}, 32'd0);
      wr(32'h4, 32'd7, 4'hF);
      repeat (3) @(posedge clk);
      #1 rd(32'h8, 32'd0, "rst_idle");

      // CTRL write with EN=1 in the same cycle the one-shot INT clears EN.
      wr(32'h4, 32'd0, 4'hF);
      wr(32'h0, 32'h9, 4'hF);
      repeat (3) @(posedge clk);
      #1 chk("race_irq_up", {31'd0, irq}, 32'd1);
      wr(32'h0, 32'h9, 4'hF);
      rd(32'h0, 32'h9, "race_en_wins");
      chk("race_pend_clr", {31'd0, irq}, 32'd0);
      repeat (3) @(posedge clk);
      #1 chk("race_refire", {31'd0, irq}, 32'd1);
      @(posedge clk);
      #1 rd(32'h0, 32'h8, "race_en_clr");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
